seven_seg_scan_n: RTL and testbench

- Parametrised N-digit multiplexed seven-segment display driver. Successor to the fixed four-digit hex scanner.
- Adds the following over the four-digit scanner: configurable digit count and dwell time, per-digit decimal points, per-digit blanking, leading-zero suppression, PWM brightness, an anti-ghosting blank gap, and frame-synchronous input capture (no tearing).
- Sits between the board-top value registers and the FPGA anode/segment pins.

---
 rtl/seg_pkg.sv | 38 +++
 rtl/hex_seg_decode.sv | 16 +
 rtl/seven_seg_scan_n.sv | 169 ++++++++++++++++
 tb/tb_seven_seg_scan_n.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants and hex glyph table
package seg_pkg;

    // Bit positions inside the 8-bit seven_seg bus {a,b,c,d,e,f,g,dp}.
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // All segments and the decimal point dark (outputs are active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {a,b,c,d,e,f,g} glyphs, indexed by nibble value.
    // Letters follow the usual mixed-case forms: A b C d E F.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h38,  // F
        7'h30,  // E
        7'h42,  // d
        7'h31,  // C
        7'h60,  // b
        7'h08,  // A
        7'h04,  // 9
        7'h00,  // 8
        7'h0F,  // 7
        7'h20,  // 6
        7'h24,  // 5
        7'h4C,  // 4
        7'h06,  // 3
        7'h12,  // 2
        7'h4F,  // 1
        7'h01   // 0
    };

endpackage

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - combinational hex nibble to active-low segment glyph
// Ports:
//   nibble : in  4 - hex digit value
//   seg_n  : out 7 - {a,b,c,d,e,f,g}, 0 = segment lit
module hex_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seven_seg_scan_n.sv
// rtl/seven_seg_scan_n.sv - N-digit multiplexed seven-segment scanner with PWM and frame capture
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   value       : in  4*DIGITS - hex nibbles, nibble i drives digit i (DIGITS-1 leftmost)
//   dp          : in  DIGITS   - decimal point per digit, 1 = lit
//   blank       : in  DIGITS   - per-digit force dark
//   lz_en       : in  1        - leading-zero suppression enable
//   bright      : in  BRIGHT_BITS - PWM duty level, all-ones = full on
//   seven_seg   : out 8        - {a,b,c,d,e,f,g,dp}, active-low
//   anode       : out DIGITS   - one-hot digit select, polarity per ANODE_ACTIVE_LOW
//   frame_start : out 1        - pulse on the first output cycle of digit DIGITS-1
module seven_seg_scan_n
    import seg_pkg::*;
#(
    parameter int DIGITS           = 4,
    parameter int DWELL_CYCLES     = 16384,
    parameter int BLANK_CYCLES     = 16,
    parameter int BRIGHT_BITS      = 3,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*DIGITS-1:0]    value,
    input  logic [DIGITS-1:0]      dp,
    input  logic [DIGITS-1:0]      blank,
    input  logic                   lz_en,
    input  logic [BRIGHT_BITS-1:0] bright,
    output logic [7:0]             seven_seg,
    output logic [DIGITS-1:0]      anode,
    output logic                   frame_start
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // dwell_cnt shifted left by BRIGHT_BITS never exceeds this width.
    localparam int PH_W  = CNT_W + BRIGHT_BITS;

    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BLANK_END  = CNT_W'(BLANK_CYCLES);
    localparam logic [PH_W-1:0]   DWELL_DIV  = PH_W'(DWELL_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_TOP    = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ANODE_OFF  = {DIGITS{ANODE_ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]       dwell_cnt_q, dwell_cnt_d;
    logic [IDX_W-1:0]       digit_idx_q, digit_idx_d;
    logic [4*DIGITS-1:0]    value_sh_q, value_sh_d;
    logic [DIGITS-1:0]      dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]      blank_sh_q, blank_sh_d;
    logic                   lz_sh_q, lz_sh_d;
    logic [BRIGHT_BITS-1:0] bright_sh_q, bright_sh_d;
    logic [7:0]             seven_seg_q, seven_seg_d;
    logic [DIGITS-1:0]      anode_q, anode_d;
    logic                   frame_start_q, frame_start_d;

    logic                   capture;
    logic [4*DIGITS-1:0]    eff_value;
    logic [DIGITS-1:0]      eff_dp;
    logic [DIGITS-1:0]      eff_blank;
    logic                   eff_lz;
    logic [BRIGHT_BITS-1:0] eff_bright;
    logic [DIGITS-1:0]      suppress;
    logic                   higher_zero;
    logic [3:0]             sel_nibble;
    logic                   sel_dp;
    logic                   sel_supp;
    logic [DIGITS-1:0]      anode_hot;
    logic [PH_W-1:0]        phase;
    logic                   lit;
    logic [6:0]             dec_seg;

    // Frame capture, counters and digit selection.
    always_comb begin
        // The first cycle of digit DIGITS-1 (also the state right after reset)
        // loads the shadows. That cycle's own output already uses the live
        // inputs, so the whole frame renders from one consistent snapshot.
        capture    = (digit_idx_q == IDX_TOP) && (dwell_cnt_q == '0);
        eff_value  = capture ? value  : value_sh_q;
        eff_dp     = capture ? dp     : dp_sh_q;
        eff_blank  = capture ? blank  : blank_sh_q;
        eff_lz     = capture ? lz_en  : lz_sh_q;
        eff_bright = capture ? bright : bright_sh_q;

        value_sh_d  = eff_value;
        dp_sh_d     = eff_dp;
        blank_sh_d  = eff_blank;
        lz_sh_d     = eff_lz;
        bright_sh_d = eff_bright;

        dwell_cnt_d = dwell_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (dwell_cnt_q == DWELL_LAST) begin
            dwell_cnt_d = '0;
            digit_idx_d = (digit_idx_q == '0) ? IDX_TOP : digit_idx_q - 1'b1;
        end

        // Walk from the leftmost digit down; a digit is a leading zero when
        // it and everything to its left is zero. Digit 0 always shows.
        suppress    = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (eff_value[i*4 +: 4] == 4'h0);
            suppress[i] = eff_blank[i] | (eff_lz & higher_zero & (i != 0));
        end

        sel_nibble = 4'h0;
        sel_dp     = 1'b0;
        sel_supp   = 1'b1;
        anode_hot  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
                sel_nibble   = eff_value[i*4 +: 4];
                sel_dp       = eff_dp[i];
                sel_supp     = suppress[i];
                anode_hot[i] = 1'b1;
            end
        end
    end

    hex_seg_decode u_hex_seg_decode (
        .nibble (sel_nibble),
        .seg_n  (dec_seg)
    );

    // PWM gating and output pattern; segments and anode are built from the
    // same selected digit so they always register together.
    always_comb begin
        phase = {dwell_cnt_q, {BRIGHT_BITS{1'b0}}} / DWELL_DIV;
        lit   = (dwell_cnt_q >= BLANK_END) && (phase <= PH_W'(eff_bright)) && !sel_supp;

        seven_seg_d   = SEG_BLANK;
        anode_d       = ANODE_OFF;
        frame_start_d = capture;
        if (lit) begin
            seven_seg_d = {dec_seg, ~sel_dp};
            anode_d     = (ANODE_ACTIVE_LOW != 0) ? ~anode_hot : anode_hot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt_q   <= '0;
            digit_idx_q   <= IDX_TOP;
            value_sh_q    <= '0;
            dp_sh_q       <= '0;
            blank_sh_q    <= '0;
            lz_sh_q       <= 1'b0;
            bright_sh_q   <= '0;
            seven_seg_q   <= SEG_BLANK;
            anode_q       <= ANODE_OFF;
            frame_start_q <= 1'b0;
        end else begin
            dwell_cnt_q   <= dwell_cnt_d;
            digit_idx_q   <= digit_idx_d;
            value_sh_q    <= value_sh_d;
            dp_sh_q       <= dp_sh_d;
            blank_sh_q    <= blank_sh_d;
            lz_sh_q       <= lz_sh_d;
            bright_sh_q   <= bright_sh_d;
            seven_seg_q   <= seven_seg_d;
            anode_q       <= anode_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seven_seg   = seven_seg_q;
    assign anode       = anode_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// tb/tb_seven_seg_scan_n.sv - self-checking bench for seven_seg_scan_n
module tb_seven_seg_scan_n;

    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic        lz;
        logic [2:0]  bright;
    } snap_t;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] an;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus for the two 4-digit builds.
    logic [15:0] value_a  = '0;
    logic [3:0]  dp_a     = '0;
    logic [3:0]  blank_a  = '0;
    logic        lz_a     = 1'b0;
    logic [2:0]  bright_a = 3'd7;
    // Stimulus for the single-digit build.
    logic [3:0]  value_c  = '0;
    logic [0:0]  dp_c     = '0;
    logic [0:0]  blank_c  = '0;
    logic        lz_c     = 1'b0;
    logic [1:0]  bright_c = 2'd3;

    logic [7:0] seg_a, seg_p, seg_c;
    logic [3:0] an_a, an_p;
    logic [0:0] an_c;
    logic       fs_a, fs_p, fs_c;

    seven_seg_scan_n #(.DIGITS(4), .DWELL_CYCLES(8), .BLANK_CYCLES(1), .BRIGHT_BITS(3), .ANODE_ACTIVE_LOW(1)) dut_a (
        .clk(clk), .rst(rst), .value(value_a), .dp(dp_a), .blank(blank_a), .lz_en(lz_a),
        .bright(bright_a), .seven_seg(seg_a), .anode(an_a), .frame_start(fs_a));

    seven_seg_scan_n #(.DIGITS(4), .DWELL_CYCLES(16), .BLANK_CYCLES(0), .BRIGHT_BITS(3), .ANODE_ACTIVE_LOW(1)) dut_p (
        .clk(clk), .rst(rst), .value(value_a), .dp(dp_a), .blank(blank_a), .lz_en(lz_a),
        .bright(bright_a), .seven_seg(seg_p), .anode(an_p), .frame_start(fs_p));

    seven_seg_scan_n #(.DIGITS(1), .DWELL_CYCLES(8), .BLANK_CYCLES(2), .BRIGHT_BITS(2), .ANODE_ACTIVE_LOW(0)) dut_c (
        .clk(clk), .rst(rst), .value(value_c), .dp(dp_c), .blank(blank_c), .lz_en(lz_c),
        .bright(bright_c), .seven_seg(seg_c), .anode(an_c), .frame_start(fs_c));

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    cyc          = 0;
    int    last_s       = 0;
    logic [6:0] glyph [16];
    snap_t snap_a, snap_p, snap_c;
    obs_t  got [3];
    obs_t  exp [3];

    // Glyph from the list of lit segment letters.
    function automatic logic [6:0] seg_of(string lit);
        logic [6:0] r = 7'h7F;
        for (int i = 0; i < lit.len(); i++) r[6 - (int'(lit[i]) - 97)] = 1'b0;
        return r;
    endfunction

    // Expected outputs for state cycle s counted from the reset release.
    function automatic obs_t model(int d_n, int w, int bl, int bb, bit act_low, int s, snap_t sn);
        obs_t e;
        int   d, k;
        bit   supp, on;
        logic [3:0] nib;
        d    = d_n - 1 - (s / w) % d_n;
        k    = s % w;
        supp = sn.blank[d] || (sn.lz && d != 0 && (sn.value >> (4 * d)) == 32'd0);
        on   = (k >= bl) && ((k * (1 << bb)) / w <= int'(sn.bright)) && !supp;
        nib  = 4'((sn.value >> (4 * d)) & 32'hF);
        e.seg = on ? {glyph[nib], ~sn.dp[d]} : 8'hFF;
        e.an  = 8'h00;
        if (on) e.an[d] = 1'b1;
        if (act_low) e.an = ~e.an;
        e.an = e.an & 8'((1 << d_n) - 1);
        e.fs = (s % (d_n * w)) == 0;
        return e;
    endfunction

    function automatic snap_t cur_a();
        return '{value: {16'h0, value_a}, dp: {4'h0, dp_a}, blank: {4'h0, blank_a}, lz: lz_a, bright: bright_a};
    endfunction

    function automatic snap_t cur_c();
        return '{value: {28'h0, value_c}, dp: {7'h0, dp_c}, blank: {7'h0, blank_c}, lz: lz_c, bright: {1'b0, bright_c}};
    endfunction

    // Advance one clock and fill got[]/exp[]; comparisons are done by callers.
    task automatic tick();
        if (!rst) begin
            if (cyc % 32 == 0) snap_a = cur_a();
            if (cyc % 64 == 0) snap_p = cur_a();
            if (cyc % 8 == 0)  snap_c = cur_c();
        end
        @(posedge clk);
        #1;
        if (rst) begin
            exp[0] = '{seg: 8'hFF, an: 8'h0F, fs: 1'b0};
            exp[1] = '{seg: 8'hFF, an: 8'h0F, fs: 1'b0};
            exp[2] = '{seg: 8'hFF, an: 8'h00, fs: 1'b0};
            last_s = -1;
            cyc    = 0;
        end else begin
            exp[0] = model(4, 8, 1, 3, 1'b1, cyc, snap_a);
            exp[1] = model(4, 16, 0, 3, 1'b1, cyc, snap_p);
            exp[2] = model(1, 8, 2, 2, 1'b0, cyc, snap_c);
            last_s = cyc;
            cyc++;
        end
        got[0] = '{seg: seg_a, an: {4'h0, an_a}, fs: fs_a};
        got[1] = '{seg: seg_p, an: {4'h0, an_p}, fs: fs_p};
        got[2] = '{seg: seg_c, an: {7'h0, an_c}, fs: fs_c};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            for (int j = 0; j < 3; j++) begin
                tests_run++;
                if (got[j].seg !== exp[j].seg) begin tests_failed++; $display("FAIL reset_seg dut%0d got %h exp %h", j, got[j].seg, exp[j].seg); end
                tests_run++;
                if (got[j].an !== exp[j].an) begin tests_failed++; $display("FAIL reset_anode dut%0d got %h exp %h", j, got[j].an, exp[j].an); end
                tests_run++;
                if (got[j].fs !== exp[j].fs) begin tests_failed++; $display("FAIL reset_fs dut%0d got %b exp %b", j, got[j].fs, exp[j].fs); end
            end
        end
    endtask

    task automatic test_scan();
        int pulses = 0;
        value_a = 16'h1234; dp_a = 4'h0; blank_a = 4'h0; lz_a = 1'b0; bright_a = 3'd7;
        value_c = 4'h5; dp_c = 1'b1; bright_c = 2'd3;
        rst = 1'b0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (fs_a === 1'b1) pulses++;
            if (last_s == 1) begin
                tests_run++;
                if (seg_a !== 8'h9F || an_a !== 4'b0111) begin
                    tests_failed++; $display("FAIL scan_first_digit got %h/%b exp 9f/0111", seg_a, an_a);
                end
            end
            for (int j = 0; j < 3; j++) begin
                tests_run++;
                if (got[j].seg !== exp[j].seg) begin tests_failed++; $display("FAIL scan_seg dut%0d s=%0d got %h exp %h", j, last_s, got[j].seg, exp[j].seg); end
                tests_run++;
                if (got[j].an !== exp[j].an) begin tests_failed++; $display("FAIL scan_anode dut%0d s=%0d got %h exp %h", j, last_s, got[j].an, exp[j].an); end
                tests_run++;
                if (got[j].fs !== exp[j].fs) begin tests_failed++; $display("FAIL scan_fs dut%0d s=%0d got %b exp %b", j, last_s, got[j].fs, exp[j].fs); end
            end
        end
        tests_run++;
        if (pulses != 2) begin tests_failed++; $display("FAIL scan_frame_count got %0d exp 2", pulses); end
    endtask

    task automatic test_tear();
        bit seen = 1'b0;
        // Move into digit 2 of dut_a before changing the value.
        for (int n = 0; n < 40 && !(cyc % 32 >= 9 && cyc % 32 <= 14); n++) tick();
        value_a = 16'hABCD;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (!seen && last_s % 32 == 1) begin
                seen = 1'b1;
                tests_run++;
                if (seg_a !== 8'h11) begin tests_failed++; $display("FAIL tear_new_frame got %h exp 11", seg_a); end
            end
            for (int j = 0; j < 3; j++) begin
                tests_run++;
                if (got[j].seg !== exp[j].seg) begin tests_failed++; $display("FAIL tear_seg dut%0d s=%0d got %h exp %h", j, last_s, got[j].seg, exp[j].seg); end
                tests_run++;
                if (got[j].an !== exp[j].an) begin tests_failed++; $display("FAIL tear_anode dut%0d s=%0d got %h exp %h", j, last_s, got[j].an, exp[j].an); end
            end
        end
    endtask

    task automatic test_lz_blank_dp();
        logic [15:0] vals [3] = '{16'h0070, 16'h0000, 16'h8888};
        logic [3:0]  blks [3] = '{4'b0000, 4'b0000, 4'b0100};
        logic [3:0]  dps  [3] = '{4'b0000, 4'b0000, 4'b0001};
        for (int p = 0; p < 3; p++) begin
            value_a = vals[p]; blank_a = blks[p]; dp_a = dps[p]; lz_a = (p < 2);
            value_c = 4'h0; lz_c = 1'b1;
            for (int n = 0; n < 128; n++) begin
                tick();
                for (int j = 0; j < 3; j++) begin
                    tests_run++;
                    if (got[j].seg !== exp[j].seg) begin tests_failed++; $display("FAIL lzbd_seg p%0d dut%0d s=%0d got %h exp %h", p, j, last_s, got[j].seg, exp[j].seg); end
                    tests_run++;
                    if (got[j].an !== exp[j].an) begin tests_failed++; $display("FAIL lzbd_anode p%0d dut%0d s=%0d got %h exp %h", p, j, last_s, got[j].an, exp[j].an); end
                end
            end
        end
        lz_a = 1'b0; lz_c = 1'b0; blank_a = '0; dp_a = '0;
    endtask

    task automatic test_bright();
        logic [2:0] lv  [3] = '{3'd0, 3'd3, 3'd7};
        int         on_exp [3] = '{8, 32, 64};
        int         on_cnt;
        value_a = 16'h1234;
        for (int p = 0; p < 3; p++) begin
            rst = 1'b1;
            tick();
            bright_a = lv[p];
            rst = 1'b0;
            on_cnt = 0;
            for (int n = 0; n < 64; n++) begin
                tick();
                if (an_p !== 4'hF) on_cnt++;
                tests_run++;
                if (got[1].an !== exp[1].an) begin tests_failed++; $display("FAIL bright_anode b%0d s=%0d got %h exp %h", lv[p], last_s, got[1].an, exp[1].an); end
                tests_run++;
                if (got[0].an !== exp[0].an) begin tests_failed++; $display("FAIL bright_anode_a b%0d s=%0d got %h exp %h", lv[p], last_s, got[0].an, exp[0].an); end
            end
            tests_run++;
            if (on_cnt != on_exp[p]) begin tests_failed++; $display("FAIL bright_duty b%0d got %0d exp %0d", lv[p], on_cnt, on_exp[p]); end
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 40 && !(cyc % 32 >= 17 && cyc % 32 <= 22); n++) tick();
        rst = 1'b1;
        tick();
        tests_run++;
        if (seg_a !== 8'hFF || an_a !== 4'hF) begin tests_failed++; $display("FAIL midrst_dark got %h/%b exp ff/1111", seg_a, an_a); end
        rst = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            for (int j = 0; j < 3; j++) begin
                tests_run++;
                if (got[j].seg !== exp[j].seg) begin tests_failed++; $display("FAIL midrst_seg dut%0d s=%0d got %h exp %h", j, last_s, got[j].seg, exp[j].seg); end
                tests_run++;
                if (got[j].an !== exp[j].an) begin tests_failed++; $display("FAIL midrst_anode dut%0d s=%0d got %h exp %h", j, last_s, got[j].an, exp[j].an); end
                tests_run++;
                if (got[j].fs !== exp[j].fs) begin tests_failed++; $display("FAIL midrst_fs dut%0d s=%0d got %b exp %b", j, last_s, got[j].fs, exp[j].fs); end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(9) == 0) value_a  = 16'($urandom);
            if ($urandom_range(15) == 0) dp_a    = 4'($urandom);
            if ($urandom_range(15) == 0) blank_a = 4'($urandom);
            if ($urandom_range(15) == 0) lz_a    = 1'($urandom);
            if ($urandom_range(15) == 0) bright_a = 3'($urandom);
            if ($urandom_range(7) == 0) value_c  = 4'($urandom);
            if ($urandom_range(15) == 0) dp_c    = 1'($urandom);
            if ($urandom_range(15) == 0) blank_c = 1'($urandom);
            if ($urandom_range(15) == 0) lz_c    = 1'($urandom);
            if ($urandom_range(15) == 0) bright_c = 2'($urandom);
            rst = ($urandom_range(499) == 0);
            tick();
            for (int j = 0; j < 3; j++) begin
                tests_run++;
                if (got[j].seg !== exp[j].seg) begin tests_failed++; $display("FAIL rand_seg dut%0d s=%0d got %h exp %h", j, last_s, got[j].seg, exp[j].seg); end
                tests_run++;
                if (got[j].an !== exp[j].an) begin tests_failed++; $display("FAIL rand_anode dut%0d s=%0d got %h exp %h", j, last_s, got[j].an, exp[j].an); end
                tests_run++;
                if (got[j].fs !== exp[j].fs) begin tests_failed++; $display("FAIL rand_fs dut%0d s=%0d got %b exp %b", j, last_s, got[j].fs, exp[j].fs); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        glyph[0]  = seg_of("abcdef");  glyph[1]  = seg_of("bc");
        glyph[2]  = seg_of("abdeg");   glyph[3]  = seg_of("abcdg");
        glyph[4]  = seg_of("bcfg");    glyph[5]  = seg_of("acdfg");
        glyph[6]  = seg_of("acdefg");  glyph[7]  = seg_of("abc");
        glyph[8]  = seg_of("abcdefg"); glyph[9]  = seg_of("abcdfg");
        glyph[10] = seg_of("abcefg");  glyph[11] = seg_of("cdefg");
        glyph[12] = seg_of("adef");    glyph[13] = seg_of("bcdeg");
        glyph[14] = seg_of("adefg");   glyph[15] = seg_of("aefg");
        snap_a = '0; snap_p = '0; snap_c = '0;

        test_reset();
        test_scan();
        test_tear();
        test_lz_blank_dp();
        test_bright();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
